// File: rtl/pe_loader_if.sv
// Bundle of the loader's job command, input word stream, PE memory write
// port, PE start/done handshake and result stream.
interface pe_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  cmd_valid;
   logic                  cmd_load_w;
   logic                  cmd_ready;
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] pe_mem_data;
   logic [ADDR_WIDTH-1:0] pe_mem_addrs;
   logic                  pe_mem_sel;
   logic                  pe_mem_wr;
   logic                  pe_start;
   logic                  pe_done;
   logic [DATA_WIDTH-1:0] pe_data_out;
   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_ready;
   logic                  busy;

   // Environment side: issues jobs and words, plays the PE, consumes results.
   modport master (
      output cmd_valid, cmd_load_w, s_valid, s_data, pe_done, pe_data_out, res_ready,
      input  cmd_ready, s_ready, pe_mem_data, pe_mem_addrs, pe_mem_sel, pe_mem_wr,
             pe_start, res_valid, res_data, busy
   );

   // Loader side.
   modport slave (
      input  cmd_valid, cmd_load_w, s_valid, s_data, pe_done, pe_data_out, res_ready,
      output cmd_ready, s_ready, pe_mem_data, pe_mem_addrs, pe_mem_sel, pe_mem_wr,
             pe_start, res_valid, res_data, busy
   );
endinterface

// File: rtl/pe_loader.sv
// pe_loader: sequences one PE job. Streams optional weights and then data into
// the PE buffers, waits two idle cycles, pulses start, captures the PE result
// and holds it on a valid/ready output until consumed.
module pe_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_ELEMS  = 9
) (
   input  logic         clk,
   input  logic         rst,
   pe_loader_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_D, GAP, START, WAIT_DONE, RESULT
   } state_t;

   // idx is one bit wider than the address so NUM_ELEMS = 2^ADDR_WIDTH fits.
   localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(NUM_ELEMS - 1);
   localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH+1)'(1);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH:0]   idx_reg, idx_next;
   logic [1:0]            gap_cnt_reg, gap_cnt_next;
   logic                  mem_wr_reg, mem_wr_next;
   logic [DATA_WIDTH-1:0] mem_data_reg, mem_data_next;
   logic [ADDR_WIDTH-1:0] mem_addrs_reg, mem_addrs_next;
   logic                  mem_sel_reg, mem_sel_next;
   logic                  start_reg, start_next;
   logic                  res_valid_reg, res_valid_next;
   logic [DATA_WIDTH-1:0] res_data_reg, res_data_next;
   logic                  s_ready_int;
   logic                  xfer;

   assign s_ready_int = (state_reg == LOAD_W) || (state_reg == LOAD_D);
   assign xfer        = bus.s_valid && s_ready_int;

   // State and registered outputs; reset abandons any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         gap_cnt_reg   <= '0;
         mem_wr_reg    <= 1'b0;
         mem_data_reg  <= '0;
         mem_addrs_reg <= '0;
         mem_sel_reg   <= 1'b0;
         start_reg     <= 1'b0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         gap_cnt_reg   <= gap_cnt_next;
         mem_wr_reg    <= mem_wr_next;
         mem_data_reg  <= mem_data_next;
         mem_addrs_reg <= mem_addrs_next;
         mem_sel_reg   <= mem_sel_next;
         start_reg     <= start_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
      end
   end

   // Next-state and next-output decode; write strobe and start are single-cycle.
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      gap_cnt_next   = gap_cnt_reg;
      mem_wr_next    = 1'b0;
      mem_data_next  = mem_data_reg;
      mem_addrs_next = mem_addrs_reg;
      mem_sel_next   = mem_sel_reg;
      start_next     = 1'b0;
      res_valid_next = res_valid_reg;
      res_data_next  = res_data_reg;

      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               idx_next     = '0;
               gap_cnt_next = '0;
               state_next   = bus.cmd_load_w ? LOAD_W : LOAD_D;
            end
         end
         LOAD_W, LOAD_D: begin
            if (xfer) begin
               mem_wr_next    = 1'b1;
               mem_data_next  = bus.s_data;
               mem_addrs_next = idx_reg[ADDR_WIDTH-1:0];
               mem_sel_next   = (state_reg == LOAD_D);
               idx_next       = idx_reg + IDX_ONE;
               // Weight->data switch happens without a bubble.
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  state_next = (state_reg == LOAD_W) ? LOAD_D : GAP;
               end
            end
         end
         GAP: begin
            // Two quiet cycles so the PE leaves its memory-write mode.
            if (gap_cnt_reg == 2'd1) begin
               gap_cnt_next = '0;
               state_next   = START;
            end else begin
               gap_cnt_next = gap_cnt_reg + 2'd1;
            end
         end
         START: begin
            start_next = 1'b1;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.pe_done) begin
               res_data_next  = bus.pe_data_out;
               res_valid_next = 1'b1;
               state_next     = RESULT;
            end
         end
         RESULT: begin
            if (bus.res_ready) begin
               res_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.cmd_ready    = (state_reg == IDLE);
   assign bus.s_ready      = s_ready_int;
   assign bus.busy         = (state_reg != IDLE);
   assign bus.pe_mem_wr    = mem_wr_reg;
   assign bus.pe_mem_data  = mem_data_reg;
   assign bus.pe_mem_addrs = mem_addrs_reg;
   assign bus.pe_mem_sel   = mem_sel_reg;
   assign bus.pe_start     = start_reg;
   assign bus.res_valid    = res_valid_reg;
   assign bus.res_data     = res_data_reg;

endmodule
